// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and sizing for alu_exec
package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int MULT_ITERS = ALU_WIDTH;

  localparam logic [3:0] AND_OP  = 4'd0;
  localparam logic [3:0] OR_OP   = 4'd1;
  localparam logic [3:0] ADD_OP  = 4'd2;
  localparam logic [3:0] SLL_OP  = 4'd3;
  localparam logic [3:0] SRL_OP  = 4'd4;
  localparam logic [3:0] SUB_OP  = 4'd5;
  localparam logic [3:0] SLT_OP  = 4'd7;
  localparam logic [3:0] MULT_OP = 4'd8;
  localparam logic [3:0] NOR_OP  = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative signed shift-add multiplier, compiled only with ALU_MULT_EN
`ifdef ALU_MULT_EN
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_ITERS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_last;

  // One step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  // w_prod is the signed result as it will be once the final step lands.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    w_prod    = r_neg ? (-w_acc_nxt) : w_acc_nxt;
  end

  assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

  // Capture magnitudes and sign on start, iterate while busy, drop everything on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (i_start && !r_busy) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_neg   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_mcand <= i_a[WIDTH-1] ? (-i_a) : i_a;
      r_acc   <= {{WIDTH{1'b0}}, (i_b[WIDTH-1] ? (-i_b) : i_b)};
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_hi   = w_prod[2*WIDTH-1:WIDTH];
  assign o_lo   = w_prod[WIDTH-1:0];

endmodule
`endif

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU; define ALU_MULT_EN to add the iterative multiplier and HI register
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         alu_control,
  input  logic [WIDTH-1:0]   alu_in_0,
  input  logic [WIDTH-1:0]   alu_in_1,
  input  logic [4:0]         shamt,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   alu_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic               zero,
  output logic               overflow
);

  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_overflow;
  logic             r_out_valid;

  logic             w_busy;
  logic             w_accept;
  logic             w_is_mult;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_sum    = alu_in_0 + alu_in_1;
  assign w_diff   = alu_in_0 - alu_in_1;

`ifdef ALU_MULT_EN
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] r_hi_out;

  assign w_is_mult = (alu_control == MULT_OP);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Launch the multiplier on an accepted MULT; fall back to IDLE on its last step.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mult) begin
          w_mul_start = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        if (w_mul_done || !w_mul_busy) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign w_busy = (r_state == MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (alu_in_0),
    .i_b     (alu_in_1),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_hi    (w_mul_hi),
    .o_lo    (w_mul_lo)
  );

  // HI keeps the last product until the next multiply completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi_out <= '0;
    end else if (w_mul_done) begin
      r_hi_out <= w_mul_hi;
    end
  end

  assign hi_out = r_hi_out;
`else
  assign w_is_mult  = 1'b0;
  assign w_busy     = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_lo   = '0;
  assign hi_out     = '0;
`endif

  // Single-cycle result and signed-overflow detection; unknown codes give 0.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (alu_control)
      AND_OP: w_res = alu_in_0 & alu_in_1;
      OR_OP:  w_res = alu_in_0 | alu_in_1;
      NOR_OP: w_res = ~(alu_in_0 | alu_in_1);
      ADD_OP: begin
        w_res = w_sum;
        w_ovf = (alu_in_0[WIDTH-1] == alu_in_1[WIDTH-1]) && (w_sum[WIDTH-1] != alu_in_0[WIDTH-1]);
      end
      SUB_OP: begin
        w_res = w_diff;
        w_ovf = (alu_in_0[WIDTH-1] != alu_in_1[WIDTH-1]) && (w_diff[WIDTH-1] != alu_in_0[WIDTH-1]);
      end
      SLL_OP: w_res = alu_in_1 << shamt;
      SRL_OP: w_res = alu_in_1 >> shamt;
      SLT_OP: w_res = {{(WIDTH-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
      default: ;
    endcase
  end

  // Output registers: multiply completion or an accepted single-cycle op loads them and pulses out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_out   <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_mul_done) begin
      r_alu_out   <= w_mul_lo;
      r_zero      <= (w_mul_lo == '0);
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_accept && !w_is_mult) begin
      r_alu_out   <= w_res;
      r_zero      <= (w_res == '0);
      r_overflow  <= w_ovf;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign busy      = w_busy;
  assign in_ready  = !w_busy;
  assign out_valid = r_out_valid;
  assign alu_out   = r_alu_out;
  assign zero      = r_zero;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - randomized self-checking bench for alu_exec against an arithmetic reference model
module tb_alu_exec;
  import alu_pkg::*;

  localparam int W = 32;
`ifdef ALU_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    alu_control;
  logic [W-1:0]  alu_in_0;
  logic [W-1:0]  alu_in_1;
  logic [4:0]    shamt;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic [W-1:0]  alu_out;
  logic [W-1:0]  hi_out;
  logic          zero;
  logic          overflow;

  int            n_chk = 0;
  int            n_err = 0;
  logic [W-1:0]  m_hi  = '0;

  alu_exec #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_control (alu_control),
    .alu_in_0    (alu_in_0),
    .alu_in_1    (alu_in_1),
    .shamt       (shamt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .alu_out     (alu_out),
    .hi_out      (hi_out),
    .zero        (zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, result} from plain signed/unsigned arithmetic.
  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    case (op)
      AND_OP: return {1'b0, a & b};
      OR_OP:  return {1'b0, a | b};
      NOR_OP: return {1'b0, ~(a | b)};
      ADD_OP: begin s = sa + sb; return {(s > SMAX) || (s < SMIN), s[W-1:0]}; end
      SUB_OP: begin s = sa - sb; return {(s > SMAX) || (s < SMIN), s[W-1:0]}; end
      SLL_OP: return {1'b0, b << sh};
      SRL_OP: return {1'b0, b >> sh};
      SLT_OP: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
      default: return '0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh);
    int         lat;
    int         nb;
    bit         is_mul;
    logic [W:0] r;
    longint     p;
    logic [W-1:0] exp_out;
    logic         exp_ovf;
    is_mul = MULT_EN && (op == MULT_OP);
    if (is_mul) begin
      p       = longint'($signed(a)) * longint'($signed(b));
      exp_out = p[W-1:0];
      exp_ovf = 1'b0;
      m_hi    = p[2*W-1:W];
    end else begin
      r       = ref_alu(op, a, b, sh);
      exp_out = r[W-1:0];
      exp_ovf = r[W];
    end
    chk({tag, "_rdy"}, in_ready, 1);
    alu_control = op;
    alu_in_0    = a;
    alu_in_1    = b;
    shamt       = sh;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    nb  = 0;
    while (!out_valid && lat < 40) begin
      nb += int'(busy);
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, is_mul ? W + 1 : 1);
    chk({tag, "_busy_cyc"}, nb, is_mul ? W : 0);
    chk({tag, "_out"}, alu_out, exp_out);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_zero"}, zero, exp_out == '0);
    chk({tag, "_hi"}, hi_out, m_hi);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'h7FFFFFFF;
      3: return 32'hFFFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [3:0] codes [12];
    int nb;
    int nov;
    codes = '{AND_OP, OR_OP, ADD_OP, SLL_OP, SRL_OP, SUB_OP, SLT_OP, MULT_OP, NOR_OP,
              4'd6, 4'd9, 4'd15};
    rst_n = 1'b0; in_valid = 1'b0; alu_control = '0;
    alu_in_0 = '0; alu_in_1 = '0; shamt = '0;
    step();
    step();
    chk("rst_out", alu_out, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    run_op("add_ovf", ADD_OP, 32'h7FFFFFFF, 32'h1, 5'd0);
    chk("add_ovf_const", alu_out, 32'h80000000);

    alu_control = SUB_OP; alu_in_0 = 32'h1234; alu_in_1 = 32'h1234; in_valid = 1'b1;
    step();
    chk("sub_out", alu_out, 0);
    chk("sub_zero", zero, 1);
    chk("sub_valid", out_valid, 1);
    alu_control = SLT_OP; alu_in_0 = 32'hFFFFFFFF; alu_in_1 = 32'h1;
    step();
    in_valid = 1'b0;
    chk("slt_out", alu_out, 1);
    chk("slt_valid", out_valid, 1);
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_hold", alu_out, 1);

    run_op("mul_neg", MULT_OP, 32'hFFFFFFFD, 32'h7, 5'd0);
`ifdef ALU_MULT_EN
    chk("mul_neg_lo_const", alu_out, 32'hFFFFFFEB);
    chk("mul_neg_hi_const", hi_out, 32'hFFFFFFFF);

    alu_control = MULT_OP; alu_in_0 = 32'h80000000; alu_in_1 = 32'h80000000; in_valid = 1'b1;
    step();
    alu_control = ADD_OP; alu_in_0 = 32'd2; alu_in_1 = 32'd3;
    nb = 0; nov = 0;
    for (int c = 1; c <= W; c++) begin
      nb  += int'(busy && !in_ready);
      nov += int'(out_valid);
      step();
    end
    chk("held_busy_cyc", nb, W);
    chk("held_no_valid", nov, 0);
    chk("mul_min_valid", out_valid, 1);
    chk("mul_min_lo", alu_out, 0);
    chk("mul_min_zero", zero, 1);
    chk("mul_min_hi", hi_out, 32'h40000000);
    chk("mul_min_ready", in_ready, 1);
    m_hi = 32'h40000000;
    step();
    in_valid = 1'b0;
    chk("held_add_out", alu_out, 5);
    chk("held_add_valid", out_valid, 1);
`else
    run_op("mul_off", MULT_OP, 32'd5, 32'd5, 5'd0);
`endif

    alu_control = MULT_OP; alu_in_0 = 32'h00012345; alu_in_1 = 32'h00000777; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("midrst_busy", busy, MULT_EN);
    rst_n = 1'b0;
    step();
    chk("midrst_out", alu_out, 0);
    chk("midrst_hi", hi_out, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy0", busy, 0);
    chk("midrst_ready", in_ready, 1);
    rst_n = 1'b1;
    m_hi  = '0;
    run_op("post_rst_add", ADD_OP, 32'd2, 32'd3, 5'd0);

    for (int i = 0; i < 150; i++) begin
      run_op("rnd", codes[$urandom_range(0, 11)], pick(), pick(), 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
